// File: rtl/alu_arbiter.sv
// Two-requester sequencer for a shared combinational ALU: round-robin grant,
// operand capture, one-cycle execute, registered result with req/ack/done pulses.
module alu_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int OPRN_WIDTH = 6,
  parameter int OPRN_MAX   = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_a,
  input  logic [DATA_WIDTH-1:0] op1_a,
  input  logic [DATA_WIDTH-1:0] op2_a,
  input  logic [OPRN_WIDTH-1:0] oprn_a,
  input  logic                  req_b,
  input  logic [DATA_WIDTH-1:0] op1_b,
  input  logic [DATA_WIDTH-1:0] op2_b,
  input  logic [OPRN_WIDTH-1:0] oprn_b,
  output logic                  ack_a,
  output logic                  ack_b,
  output logic                  done_a,
  output logic                  done_b,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  result_zero,
  output logic                  err,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] alu_op1,
  output logic [DATA_WIDTH-1:0] alu_op2,
  output logic [OPRN_WIDTH-1:0] alu_oprn,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic                  alu_zero
);

  // state   | meaning
  // ST_IDLE | waiting for a request; grant taken on this edge
  // ST_EXEC | captured operands drive the ALU; result registered at edge
  // ST_DONE | done pulse visible for the granted requester

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_t;

  localparam logic [OPRN_WIDTH-1:0] OPRN_MAX_L = OPRN_WIDTH'(OPRN_MAX);

  state_t                  state_q, state_d;
  logic                    last_q;   // 1 = B served last
  logic                    grant_q;  // 1 = B currently granted
  logic                    take;
  logic                    pick_b;
  logic                    legal;
  logic [OPRN_WIDTH-1:0]   sel_oprn;

  always_comb begin
    state_d  = state_q;
    take     = 1'b0;
    pick_b   = 1'b0;
    sel_oprn = oprn_a;
    legal    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_a || req_b) begin
          take     = 1'b1;
          pick_b   = req_b && (!req_a || !last_q);
          sel_oprn = pick_b ? oprn_b : oprn_a;
          legal    = (sel_oprn != '0) && (sel_oprn <= OPRN_MAX_L);
          state_d  = legal ? ST_EXEC : ST_DONE;
        end
      end
      ST_EXEC: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      last_q      <= 1'b1;
      grant_q     <= 1'b0;
      ack_a       <= 1'b0;
      ack_b       <= 1'b0;
      done_a      <= 1'b0;
      done_b      <= 1'b0;
      result      <= '0;
      result_zero <= 1'b0;
      err         <= 1'b0;
      alu_op1     <= '0;
      alu_op2     <= '0;
      alu_oprn    <= '0;
    end else begin
      state_q <= state_d;
      ack_a   <= 1'b0;
      ack_b   <= 1'b0;
      done_a  <= 1'b0;
      done_b  <= 1'b0;
      if (take) begin
        alu_op1  <= pick_b ? op1_b : op1_a;
        alu_op2  <= pick_b ? op2_b : op2_a;
        alu_oprn <= legal ? sel_oprn : '0;
        ack_a    <= !pick_b;
        ack_b    <= pick_b;
        last_q   <= pick_b;
        grant_q  <= pick_b;
        // Illegal op code skips EXEC and completes on the grant edge.
        if (!legal) begin
          result      <= '0;
          result_zero <= 1'b0;
          err         <= 1'b1;
          done_a      <= !pick_b;
          done_b      <= pick_b;
        end
      end
      if (state_q == ST_EXEC) begin
        result      <= alu_out;
        result_zero <= alu_zero;
        err         <= 1'b0;
        done_a      <= !grant_q;
        done_b      <= grant_q;
      end
    end
  end

  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU, schedule-based expectation model with
// per-cycle compare, and directed scenarios with literal expectations.
module tb_alu_arbiter;
  localparam int DW   = 32;
  localparam int OW   = 6;
  localparam int OMAX = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_a = 1'b0, req_b = 1'b0;
  logic [DW-1:0] op1_a = '0, op2_a = '0, op1_b = '0, op2_b = '0;
  logic [OW-1:0] oprn_a = '0, oprn_b = '0;
  logic          ack_a, ack_b, done_a, done_b, result_zero, err, busy;
  logic [DW-1:0] result, alu_op1, alu_op2, alu_out;
  logic [OW-1:0] alu_oprn;
  logic          alu_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_WIDTH(DW), .OPRN_WIDTH(OW), .OPRN_MAX(OMAX)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .op1_a(op1_a), .op2_a(op2_a), .oprn_a(oprn_a),
    .req_b(req_b), .op1_b(op1_b), .op2_b(op2_b), .oprn_b(oprn_b),
    .ack_a(ack_a), .ack_b(ack_b), .done_a(done_a), .done_b(done_b),
    .result(result), .result_zero(result_zero), .err(err), .busy(busy),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_oprn(alu_oprn),
    .alu_out(alu_out), .alu_zero(alu_zero)
  );

  function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [OW-1:0] op);
    case (op)
      1: return a + b;
      2: return a - b;
      3: return a * b;
      4: return a >> b;
      5: return a << b;
      6: return a & b;
      7: return a | b;
      8: return ~(a | b);
      9: return ($signed(a) < $signed(b)) ? 1 : 0;
      default: return '0;
    endcase
  endfunction

  assign alu_out  = alu_f(alu_op1, alu_op2, alu_oprn);
  assign alu_zero = (alu_out == '0);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expectation model: a request seen while idle is scheduled as ack/done/idle
  // times in edge numbers, with the result computed from the request's operands.
  int            cyc = 0;
  bit            mvalid = 0;
  int            idle_t = 0, ack_t = -10, done_t = -10;
  bit            who_b = 0, last_b = 1;
  logic [DW-1:0] p_result = '0, e_result = '0, e_op1 = '0, e_op2 = '0;
  logic [OW-1:0] e_oprn = '0;
  bit            p_zero = 0, p_err = 0, e_zero = 0, e_err = 0;
  bit            e_ack_a = 0, e_ack_b = 0, e_done_a = 0, e_done_b = 0, e_busy = 0;

  initial forever begin
    logic [OW-1:0] op;
    logic [DW-1:0] a, b;
    bit lg;
    @(posedge clk);
    cyc++;
    if (rst) begin
      mvalid = 1; idle_t = cyc; ack_t = -10; done_t = -10; last_b = 1; who_b = 0;
      e_result = '0; e_zero = 0; e_err = 0; e_op1 = '0; e_op2 = '0; e_oprn = '0;
    end else if (mvalid) begin
      if (idle_t <= cyc - 1 && (req_a || req_b)) begin
        who_b  = req_b && (!req_a || !last_b);
        last_b = who_b;
        op = who_b ? oprn_b : oprn_a;
        a  = who_b ? op1_b : op1_a;
        b  = who_b ? op2_b : op2_a;
        lg = (op >= 1) && (op <= OMAX);
        e_op1 = a; e_op2 = b; e_oprn = lg ? op : '0;
        p_result = lg ? alu_f(a, b, op) : '0;
        p_zero   = lg && (p_result == '0);
        p_err    = !lg;
        ack_t  = cyc;
        done_t = lg ? cyc + 1 : cyc;
        idle_t = lg ? cyc + 2 : cyc + 1;
      end
      if (done_t == cyc) begin
        e_result = p_result; e_zero = p_zero; e_err = p_err;
      end
    end
    e_ack_a  = (ack_t == cyc) && !who_b;
    e_ack_b  = (ack_t == cyc) && who_b;
    e_done_a = (done_t == cyc) && !who_b;
    e_done_b = (done_t == cyc) && who_b;
    e_busy   = cyc < idle_t;
  end

  initial forever begin
    @(posedge clk); #1;
    if (mvalid) begin
      chk("ack_a", ack_a, e_ack_a);
      chk("ack_b", ack_b, e_ack_b);
      chk("done_a", done_a, e_done_a);
      chk("done_b", done_b, e_done_b);
      chk("result", result, e_result);
      chk("result_zero", result_zero, e_zero);
      chk("err", err, e_err);
      chk("busy", busy, e_busy);
      chk("alu_op1", alu_op1, e_op1);
      chk("alu_op2", alu_op2, e_op2);
      chk("alu_oprn", alu_oprn, e_oprn);
    end
  end

  wire [3:0] pulses = {done_b, done_a, ack_b, ack_a};

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1; req_a = 0; req_b = 0;
    tick(); tick();
    rst = 0;
  endtask

  // sel: 0 ack_a, 1 ack_b, 2 done_a, 3 done_b; returns ticks taken
  task automatic wait_sig(input int sel, input string nm, output int n);
    n = 0;
    while (n < 20) begin
      tick();
      n++;
      if (pulses[sel]) return;
    end
    checks++; errors++;
    $display("FAIL %s: timeout waiting for pulse %0d", nm, sel);
  endtask

  task automatic set_a(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic [OW-1:0] o);
    op1_a = x; op2_a = y; oprn_a = o; req_a = 1;
  endtask

  task automatic set_b(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic [OW-1:0] o);
    op1_b = x; op2_b = y; oprn_b = o; req_b = 1;
  endtask

  initial begin
    int n, na, nb, nd, nidle;
    do_reset();
    chk("rst_result", result, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_oprn", alu_oprn, 0);
    chk("rst_acks", {ack_a, ack_b, done_a, done_b}, 0);

    // 1: A alone, 10+10
    set_a(10, 10, 1);
    wait_sig(0, "t1_ack_a", n);
    chk("t1_ack_latency", n, 1);
    req_a = 0;
    wait_sig(2, "t1_done_a", n);
    chk("t1_done_latency", n, 1);
    chk("t1_result", result, 20);
    chk("t1_zero", result_zero, 0);
    chk("t1_err", err, 0);
    tick();

    // 2: simultaneous A (10-10) and B (-15*15)
    do_reset();
    set_a(10, 10, 2);
    set_b(-15, 15, 3);
    wait_sig(0, "t2_ack_a", n);
    req_a = 0;
    wait_sig(2, "t2_done_a", n);
    chk("t2_a_result", result, 0);
    chk("t2_a_zero", result_zero, 1);
    wait_sig(1, "t2_ack_b", n);
    chk("t2_b_gap", n, 2);
    req_b = 0;
    wait_sig(3, "t2_done_b", n);
    chk("t2_b_result", result, 32'hFFFFFF1F);
    chk("t2_b_zero", result_zero, 0);
    tick();

    // 3: both held for 12 cycles
    do_reset();
    set_a(6, 7, 3);
    set_b(32'hF0, 32'h0F, 7);
    na = 0; nb = 0; nd = 0; nidle = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      na += int'(ack_a); nb += int'(ack_b);
      nd += int'(done_a) + int'(done_b);
      nidle += int'(!busy);
    end
    req_a = 0; req_b = 0;
    chk("t3_acks_a", na, 2);
    chk("t3_acks_b", nb, 2);
    chk("t3_dones", nd, 4);
    chk("t3_idle_cycles", nidle, 4);
    tick(); tick();

    // 4: illegal op codes from B, then legal slt
    do_reset();
    set_b(5, 6, 0);
    wait_sig(1, "t4_ack_b0", n);
    chk("t4_done_b0", done_b, 1);
    chk("t4_err0", err, 1);
    chk("t4_result0", result, 0);
    chk("t4_oprn0", alu_oprn, 0);
    set_b(5, 6, 10);
    wait_sig(1, "t4_ack_b10", n);
    chk("t4_done_b10", done_b, 1);
    chk("t4_err10", err, 1);
    chk("t4_oprn10", alu_oprn, 0);
    set_b(-30, -30, 9);
    wait_sig(1, "t4_ack_slt", n);
    req_b = 0;
    wait_sig(3, "t4_done_slt", n);
    chk("t4_slt_err", err, 0);
    chk("t4_slt_result", result, 0);
    chk("t4_slt_zero", result_zero, 1);
    tick();

    // 5: reset during EXEC abandons the op
    do_reset();
    set_a(5, 3, 2);
    wait_sig(0, "t5_ack_a", n);
    set_b(7, 1, 1);
    rst = 1;
    tick();
    chk("t5_rst_done", {done_a, done_b, ack_a, ack_b}, 0);
    chk("t5_rst_result", result, 0);
    chk("t5_rst_alu_op1", alu_op1, 0);
    chk("t5_rst_busy", busy, 0);
    rst = 0;
    n = 0;
    while (n < 10 && !(ack_a || ack_b)) begin tick(); n++; end
    chk("t5_first_grant", {ack_a, ack_b}, 2'b10);
    req_a = 0; req_b = 0;
    for (int i = 0; i < 6; i++) tick();

    // 6: operand change after ACK has no effect
    do_reset();
    set_a(25, -25, 1);
    wait_sig(0, "t6_ack_a", n);
    op1_a = 99; req_a = 0;
    wait_sig(2, "t6_done_a", n);
    chk("t6_result", result, 0);
    chk("t6_zero", result_zero, 1);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Two-requester sequencer that shares the single combinational ALU between requesters A and B (e.g. the control unit and the address-generation path).
- Latches the granted requester's operands and operation code, drives the ALU for one cycle, then registers OUT/ZERO into a result holding register.
- Handles each operation with a req/ack/done handshake, round-robin fairness and illegal-opcode rejection.
- Sits between the requesters and the ALU instance; the ALU stays purely combinational.

Parameters:
DATA_WIDTH, 32, operand/result width (matches data bus width)
OPRN_WIDTH, 6, ALU operation code width
OPRN_MAX, 9, highest legal op code (1=add,2=sub,3=mul,4=shr,5=shl,6=and,7=or,8=nor,9=slt)

Ports:
CLK  in  1  system clock, all state on rising edge
RST  in  1  synchronous, active-high reset
REQ_A  in  1  requester A operation request (level)
OP1_A  in  DATA_WIDTH  A operand 1
OP2_A  in  DATA_WIDTH  A operand 2
OPRN_A  in  OPRN_WIDTH  A op code
REQ_B / OP1_B / OP2_B / OPRN_B  in  1/DATA_WIDTH/DATA_WIDTH/OPRN_WIDTH  same for B
ACK_A, ACK_B  out  1  one-cycle pulse: request accepted, operands captured
DONE_A, DONE_B  out  1  one-cycle pulse: RESULT/RESULT_ZERO/ERR valid for that requester
RESULT  out  DATA_WIDTH  registered ALU result, held until next capture
RESULT_ZERO  out  1  registered ALU ZERO flag
ERR  out  1  registered: last operation had an illegal op code
BUSY  out  1  high in any state other than IDLE
ALU_OP1, ALU_OP2  out  DATA_WIDTH  registered drive to ALU OP1/OP2
ALU_OPRN  out  OPRN_WIDTH  registered drive to ALU OPRN
ALU_OUT  in  DATA_WIDTH  ALU OUT
ALU_ZERO  in  1  ALU ZERO

Behaviour:
- Reset (RST=1 at edge, from any state): state IDLE; all outputs 0 (ACK_*, DONE_*, RESULT, RESULT_ZERO, ERR, BUSY, ALU_OP1/OP2/OPRN); round-robin pointer LAST=B, so A wins the first tie. An operation in flight is abandoned: no ACK/DONE is issued for it.
- States: IDLE, EXEC, DONE.
- IDLE:
  - No REQ: stay.
  - One REQ: grant it.
  - Both REQ: grant the requester not equal to LAST.
  - On grant edge: ALU_OP1/OP2/OPRN <= granted operands; ACK_x <= 1; LAST <= x; GRANT <= x.
  - Next state is EXEC if 1 <= OPRN <= OPRN_MAX, else DONE with ERR pending.
- EXEC (1 cycle): ALU settles combinationally. At edge: RESULT <= ALU_OUT, RESULT_ZERO <= ALU_ZERO, ERR <= 0, DONE_GRANT <= 1; go to DONE.
- Illegal op: bypasses EXEC. At the grant edge, ALU_OPRN <= 0. On entering DONE: RESULT <= 0, RESULT_ZERO <= 0, ERR <= 1, DONE_GRANT <= 1.
- DONE (1 cycle): DONE pulse visible; go to IDLE. No grant is taken in DONE.
- Latency:
  - Legal op: ACK in cycle after grant edge; DONE 2 cycles after grant edge.
  - Illegal op: ACK and DONE in the same cycle.
  - Throughput: one legal op per 3 cycles.
- Handshake rules:
  - Operands must be stable only at the grant edge; changes after ACK do not affect the result.
  - REQ still high when IDLE is re-entered is a new request.
  - Requester drops REQ on seeing ACK if no further op is wanted.
- RESULT, RESULT_ZERO and ERR hold their values between operations; only DONE qualifies them.
- ALU_OP*/ALU_OPRN hold their last values while IDLE; they do not follow the REQ inputs.
- Arithmetic: none inside the block; RESULT is ALU_OUT verbatim (two's complement, DATA_WIDTH wrap owned by ALU).
- Simultaneous events:
  - REQ toggling during EXEC/DONE is ignored.
  - RST dominates all other inputs.

Test Plan:
1. After reset, A only: OP1=10, OP2=10, OPRN=1 -> ACK_A next cycle; DONE_A 2 cycles after grant; RESULT=20, RESULT_ZERO=0, ERR=0; ACK_B/DONE_B never assert.
2. After reset, A (10-10, OPRN=2) and B (-15*15, OPRN=3) on the same cycle -> A served first with RESULT=0, RESULT_ZERO=1. Then B with RESULT=32'hFFFFFF1F (-225), RESULT_ZERO=0. B's grant at the first IDLE edge after A's DONE.
3. REQ_A and REQ_B held high for 12 cycles -> grants alternate A,B,A,B; DONE pulses every 3 cycles; BUSY low only one cycle per op.
4. B with OPRN=0, then OPRN=10 -> each gives ACK_B and DONE_B in the same cycle with ERR=1, RESULT=0; ALU_OPRN=0; next legal op (9, slt -30,-30) gives ERR=0, RESULT=0, RESULT_ZERO=1.
5. A legal op with RST=1 in the EXEC cycle -> no DONE_A; all outputs 0 next cycle. With both REQs held after RST drops, A is granted first.
6. A grants add 25 + -25, then OP1_A changes to 99 in the ACK cycle -> RESULT=0, RESULT_ZERO=1 (captured operands used).
